// File: rtl/rolling_mark_board_pkg.sv
// Shared constants for the vanishing-mark board store.
// Response codes and the empty-cell mark value.
package rolling_mark_pkg;

    localparam logic [1:0] RESP_OK        = 2'b00;
    localparam logic [1:0] RESP_OCCUPIED  = 2'b01;
    localparam logic [1:0] RESP_BAD_ARG   = 2'b10;
    localparam logic [1:0] RESP_PREEMPTED = 2'b11;

    localparam int EMPTY_MARK = 0;
    localparam int CNT_W      = 3;
    localparam int PLR_W      = 2;

endpackage

// File: rtl/rolling_mark_board_if.sv
// Request/response bundle between the move FSM and the board store.
// The board store takes the slave side.
interface rolling_mark_board_if
    import rolling_mark_pkg::*;
#(
    parameter int CELLS   = 9,
    parameter int POS_W   = 4,
    parameter int PLAYERS = 2,
    parameter int MARK_W  = 2
);

    logic                       clear;
    logic                       move_valid;
    logic [PLR_W-1:0]           move_player;
    logic [POS_W-1:0]           move_pos;
    logic                       undo_valid;
    logic [PLR_W-1:0]           undo_player;
    logic [CELLS*MARK_W-1:0]    board;
    logic [CELLS-1:0]           fade_mask;
    logic [PLAYERS*CNT_W-1:0]   live_cnt;
    logic                       resp_valid;
    logic [1:0]                 resp_code;
    logic                       evict_valid;
    logic [POS_W-1:0]           evict_pos;

    modport master (
        output clear, move_valid, move_player, move_pos,
        output undo_valid, undo_player,
        input  board, fade_mask, live_cnt,
        input  resp_valid, resp_code, evict_valid, evict_pos
    );

    modport slave (
        input  clear, move_valid, move_player, move_pos,
        input  undo_valid, undo_player,
        output board, fade_mask, live_cnt,
        output resp_valid, resp_code, evict_valid, evict_pos
    );

endinterface

// File: rtl/rolling_mark_board_ring.sv
// Per-player move history: circular buffer of cell positions.
// Push and pop-oldest may land in the same cycle (same slot when full).
module mark_history_ring
    import rolling_mark_pkg::*;
#(
    parameter int KEEP  = 3,
    parameter int POS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_oldest_i,
    input  logic             pop_newest_i,
    input  logic [POS_W-1:0] push_pos_i,
    output logic [POS_W-1:0] oldest_pos_o,
    output logic [POS_W-1:0] newest_pos_o,
    output logic [CNT_W-1:0] count_o,
    output logic [POS_W-1:0] oldest_nxt_o,
    output logic [CNT_W-1:0] count_nxt_o
);

    localparam int PW = (KEEP > 1) ? $clog2(KEEP) : 1;

    logic [POS_W-1:0] mem_q [KEEP];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == KEEP - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] prv(input logic [PW-1:0] p);
        return (p == '0) ? PW'(KEEP - 1) : p - 1'b1;
    endfunction

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        wr     = 1'b0;
        if (clear_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_i) begin
                wr     = 1'b1;
                tail_d = nxt(tail_q);
                cnt_d  = cnt_q + 1'b1;
            end
            if (pop_oldest_i) begin
                head_d = nxt(head_q);
                cnt_d  = cnt_d - 1'b1;
            end
            if (pop_newest_i) begin
                tail_d = prv(tail_q);
                cnt_d  = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < KEEP; i++) mem_q[i] <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (wr) mem_q[tail_q] <= push_pos_i;
        end
    end

    assign oldest_pos_o = mem_q[head_q];
    assign newest_pos_o = mem_q[prv(tail_q)];
    assign count_o      = cnt_q;
    assign count_nxt_o  = cnt_d;
    // A slot written this cycle may already be the new oldest entry.
    assign oldest_nxt_o = (wr && tail_q == head_d) ? push_pos_i
                                                   : mem_q[head_d];

endmodule

// File: rtl/rolling_mark_board.sv
// Vanishing-mark board store: each player keeps at most KEEP marks,
// with undo, occupancy check, fade mask and a registered response.
module rolling_mark_board
    import rolling_mark_pkg::*;
#(
    parameter int CELLS   = 9,
    parameter int POS_W   = 4,
    parameter int PLAYERS = 2,
    parameter int KEEP    = 3,
    parameter int MARK_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    rolling_mark_board_if.slave bus
);

    logic [CELLS*MARK_W-1:0] board_q, board_d;
    logic [CELLS-1:0]        fade_q, fade_d;
    logic                    rv_q, rv_d;
    logic [1:0]              code_q, code_d;
    logic                    ev_q, ev_d;
    logic [POS_W-1:0]        evpos_q, evpos_d;

    logic [PLAYERS-1:0] push, pop_old, pop_new;
    logic               ring_clr;
    logic [POS_W-1:0]   oldest [PLAYERS];
    logic [POS_W-1:0]   newest [PLAYERS];
    logic [POS_W-1:0]   oldest_nx [PLAYERS];
    logic [CNT_W-1:0]   cnt [PLAYERS];
    logic [CNT_W-1:0]   cnt_nx [PLAYERS];

    for (genvar p = 0; p < PLAYERS; p++) begin : g_ring
        mark_history_ring #(
            .KEEP  (KEEP),
            .POS_W (POS_W)
        ) u_ring (
            .clk          (clk),
            .rst          (rst),
            .clear_i      (ring_clr),
            .push_i       (push[p]),
            .pop_oldest_i (pop_old[p]),
            .pop_newest_i (pop_new[p]),
            .push_pos_i   (bus.move_pos),
            .oldest_pos_o (oldest[p]),
            .newest_pos_o (newest[p]),
            .count_o      (cnt[p]),
            .oldest_nxt_o (oldest_nx[p]),
            .count_nxt_o  (cnt_nx[p])
        );
        assign bus.live_cnt[p*CNT_W +: CNT_W] = cnt[p];
    end

    always_comb begin
        board_d  = board_q;
        rv_d     = 1'b0;
        code_d   = code_q;
        ev_d     = 1'b0;
        evpos_d  = evpos_q;
        push     = '0;
        pop_old  = '0;
        pop_new  = '0;
        ring_clr = 1'b0;
        if (bus.clear) begin
            ring_clr = 1'b1;
            board_d  = '0;
            if (bus.move_valid || bus.undo_valid) begin
                rv_d   = 1'b1;
                code_d = RESP_PREEMPTED;
            end
        end else if (bus.undo_valid) begin
            rv_d   = 1'b1;
            code_d = RESP_BAD_ARG;
            for (int p = 0; p < PLAYERS; p++) begin
                if (int'(bus.undo_player) == p && cnt[p] != '0) begin
                    pop_new[p] = 1'b1;
                    board_d[int'(newest[p])*MARK_W +: MARK_W] = '0;
                    code_d = RESP_OK;
                end
            end
        end else if (bus.move_valid) begin
            rv_d = 1'b1;
            if (int'(bus.move_pos) >= CELLS ||
                int'(bus.move_player) >= PLAYERS) begin
                code_d = RESP_BAD_ARG;
            end else if (board_q[int'(bus.move_pos)*MARK_W +: MARK_W]
                         != MARK_W'(EMPTY_MARK)) begin
                code_d = RESP_OCCUPIED;
            end else begin
                code_d = RESP_OK;
                for (int p = 0; p < PLAYERS; p++) begin
                    if (int'(bus.move_player) == p) begin
                        push[p] = 1'b1;
                        if (int'(cnt[p]) == KEEP) begin
                            pop_old[p] = 1'b1;
                            board_d[int'(oldest[p])*MARK_W +: MARK_W] = '0;
                            ev_d    = 1'b1;
                            evpos_d = oldest[p];
                        end
                        board_d[int'(bus.move_pos)*MARK_W +: MARK_W] =
                            MARK_W'(p + 1);
                    end
                end
            end
        end
        fade_d = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            if (int'(cnt_nx[p]) == KEEP) fade_d[oldest_nx[p]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            board_q <= '0;
            fade_q  <= '0;
            rv_q    <= 1'b0;
            code_q  <= RESP_OK;
            ev_q    <= 1'b0;
            evpos_q <= '0;
        end else begin
            board_q <= board_d;
            fade_q  <= fade_d;
            rv_q    <= rv_d;
            code_q  <= code_d;
            ev_q    <= ev_d;
            evpos_q <= evpos_d;
        end
    end

    assign bus.board       = board_q;
    assign bus.fade_mask   = fade_q;
    assign bus.resp_valid  = rv_q;
    assign bus.resp_code   = code_q;
    assign bus.evict_valid = ev_q;
    assign bus.evict_pos   = evpos_q;

endmodule

// File: tb/tb_rolling_mark_board.sv
// Bench for rolling_mark_board: directed table, random traffic against
// a queue-based board model, and a mid-cycle asynchronous reset.
module tb_rolling_mark_board;
    import rolling_mark_pkg::*;

    localparam int CELLS   = 9;
    localparam int POS_W   = 4;
    localparam int PLAYERS = 2;
    localparam int KEEP    = 3;
    localparam int MARK_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    rolling_mark_board_if #(
        .CELLS(CELLS), .POS_W(POS_W), .PLAYERS(PLAYERS), .MARK_W(MARK_W)
    ) bus ();

    rolling_mark_board #(
        .CELLS(CELLS), .POS_W(POS_W), .PLAYERS(PLAYERS),
        .KEEP(KEEP), .MARK_W(MARK_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: board as cell array, history as per-player queues.
    int         brd [CELLS];
    int         hist [PLAYERS][$];
    logic       m_rv;
    logic [1:0] m_code;
    logic       m_ev;
    int         m_evpos;

    typedef struct {
        bit         clr;
        bit         mv;
        int         mp;
        int         mpos;
        bit         un;
        int         up;
        bit         rv;
        logic [1:0] code;
        bit         ev;
        int         evpos;
    } vec_t;

    vec_t tbl [16];

    function automatic void m_reset();
        for (int i = 0; i < CELLS; i++) brd[i] = 0;
        for (int p = 0; p < PLAYERS; p++) hist[p].delete();
        m_rv = 0; m_code = 0; m_ev = 0; m_evpos = 0;
    endfunction

    function automatic void m_step(bit clr, bit mv, int mp, int mpos,
                                   bit un, int up);
        int o;
        m_rv = 0;
        m_ev = 0;
        if (clr) begin
            for (int i = 0; i < CELLS; i++) brd[i] = 0;
            for (int p = 0; p < PLAYERS; p++) hist[p].delete();
            if (mv || un) begin m_rv = 1; m_code = RESP_PREEMPTED; end
        end else if (un) begin
            m_rv = 1;
            if (up >= PLAYERS) m_code = RESP_BAD_ARG;
            else if (hist[up].size() == 0) m_code = RESP_BAD_ARG;
            else begin
                o = hist[up].pop_back();
                brd[o] = 0;
                m_code = RESP_OK;
            end
        end else if (mv) begin
            m_rv = 1;
            if (mpos >= CELLS || mp >= PLAYERS) m_code = RESP_BAD_ARG;
            else if (brd[mpos] != 0) m_code = RESP_OCCUPIED;
            else begin
                if (hist[mp].size() == KEEP) begin
                    o = hist[mp].pop_front();
                    brd[o] = 0;
                    m_ev = 1;
                    m_evpos = o;
                end
                hist[mp].push_back(mpos);
                brd[mpos] = mp + 1;
                m_code = RESP_OK;
            end
        end
    endfunction

    function automatic logic [CELLS*MARK_W-1:0] exp_board();
        logic [CELLS*MARK_W-1:0] b = '0;
        for (int i = 0; i < CELLS; i++) b[i*MARK_W +: MARK_W] = 2'(brd[i]);
        return b;
    endfunction

    function automatic logic [CELLS-1:0] exp_fade();
        logic [CELLS-1:0] f = '0;
        for (int p = 0; p < PLAYERS; p++)
            if (hist[p].size() == KEEP) f[hist[p][0]] = 1'b1;
        return f;
    endfunction

    function automatic logic [PLAYERS*3-1:0] exp_live();
        logic [PLAYERS*3-1:0] l = '0;
        for (int p = 0; p < PLAYERS; p++) l[p*3 +: 3] = 3'(hist[p].size());
        return l;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("board", 32'(bus.board), 32'(exp_board()));
        chk("fade_mask", 32'(bus.fade_mask), 32'(exp_fade()));
        chk("live_cnt", 32'(bus.live_cnt), 32'(exp_live()));
        chk("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
        chk("evict_valid", 32'(bus.evict_valid), 32'(m_ev));
        chk("evict_pos", 32'(bus.evict_pos), 32'(m_evpos));
        if (m_rv) chk("resp_code", 32'(bus.resp_code), 32'(m_code));
    endtask

    task automatic set_idle();
        bus.clear = 0; bus.move_valid = 0; bus.move_player = 0;
        bus.move_pos = 0; bus.undo_valid = 0; bus.undo_player = 0;
    endtask

    task automatic drive(bit clr, bit mv, int mp, int mpos, bit un, int up);
        @(negedge clk);
        bus.clear       = clr;
        bus.move_valid  = mv;
        bus.move_player = 2'(mp);
        bus.move_pos    = 4'(mpos);
        bus.undo_valid  = un;
        bus.undo_player = 2'(up);
        m_step(clr, mv, mp, mpos, un, up);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        //          clr mv mp pos un up  rv code            ev evpos
        tbl[0]  = '{0, 1, 0, 0, 0, 0, 1, RESP_OK,        0, 0};
        tbl[1]  = '{0, 1, 0, 1, 0, 0, 1, RESP_OK,        0, 0};
        tbl[2]  = '{0, 1, 0, 2, 0, 0, 1, RESP_OK,        0, 0};
        tbl[3]  = '{0, 1, 0, 4, 0, 0, 1, RESP_OK,        1, 0};
        tbl[4]  = '{0, 1, 1, 1, 0, 0, 1, RESP_OCCUPIED,  0, 0};
        tbl[5]  = '{0, 1, 1, 9, 0, 0, 1, RESP_BAD_ARG,   0, 0};
        tbl[6]  = '{0, 1, 2, 5, 0, 0, 1, RESP_BAD_ARG,   0, 0};
        tbl[7]  = '{0, 1, 1, 3, 0, 0, 1, RESP_OK,        0, 0};
        tbl[8]  = '{0, 1, 1, 5, 0, 0, 1, RESP_OK,        0, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 1, 1, RESP_OK,        0, 0};
        tbl[10] = '{0, 0, 0, 0, 1, 1, 1, RESP_OK,        0, 0};
        tbl[11] = '{0, 0, 0, 0, 1, 1, 1, RESP_BAD_ARG,   0, 0};
        tbl[12] = '{0, 1, 1, 7, 0, 0, 1, RESP_OK,        0, 0};
        tbl[13] = '{0, 1, 0, 6, 1, 1, 1, RESP_OK,        0, 0};
        tbl[14] = '{1, 1, 0, 3, 0, 0, 1, RESP_PREEMPTED, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, RESP_OK,        0, 0};

        set_idle();
        m_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_code", 32'(bus.resp_code), 32'(RESP_OK));
        @(negedge clk);
        rst = 1;

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].mv, tbl[i].mp, tbl[i].mpos,
                  tbl[i].un, tbl[i].up);
            chk($sformatf("tbl%0d_rv", i), 32'(bus.resp_valid), 32'(tbl[i].rv));
            if (tbl[i].rv)
                chk($sformatf("tbl%0d_code", i), 32'(bus.resp_code),
                    32'(tbl[i].code));
            chk($sformatf("tbl%0d_ev", i), 32'(bus.evict_valid),
                32'(tbl[i].ev));
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_evpos", i), 32'(bus.evict_pos),
                    32'(tbl[i].evpos));
        end

        for (int n = 0; n < 400; n++) begin
            int r;
            bit clr, mv, un;
            r   = int'($urandom_range(0, 99));
            clr = (r < 4);
            un  = (r >= 4 && r < 24) || ($urandom_range(0, 9) == 0);
            mv  = (r >= 20) || ($urandom_range(0, 9) == 0);
            drive(clr, mv, int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 10)), un,
                  int'($urandom_range(0, 2)));
        end

        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 0, 2, 0, 0);
        chk("full_fade", 32'(bus.fade_mask), 32'h1);
        @(negedge clk);
        set_idle();
        @(posedge clk);
        #3;
        rst = 0;
        m_reset();
        #1;
        check_all();
        chk("async_code", 32'(bus.resp_code), 32'(RESP_OK));
        @(negedge clk);
        bus.move_valid = 1;
        bus.move_pos   = 4'd5;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        set_idle();
        rst = 1;
        drive(0, 1, 0, 0, 0, 0);
        chk("post_rst_live", 32'(bus.live_cnt), 32'h1);
        chk("post_rst_code", 32'(bus.resp_code), 32'(RESP_OK));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
